// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, CON bit
// positions and the 2-bit state encodings of the TX and RX sequencers.
package uart_mmio_pkg;

  localparam logic [31:0] TXD_OFS = 32'd0;
  localparam logic [31:0] RXD_OFS = 32'd4;
  localparam logic [31:0] CON_OFS = 32'd8;

  localparam int CON_RX_INT_EN = 0;
  localparam int CON_TX_INT_EN = 1;
  localparam int CON_RX_VALID  = 2;
  localparam int CON_TX_BUSY   = 3;
  localparam int CON_TX_DONE   = 4;
  localparam int CON_FRAME_ERR = 5;
  localparam int CON_OVERRUN   = 6;
  localparam int CON_W         = 7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fsm.sv
// 8N1 receiver: 2-flop synchronizer, mid-start validation, mid-bit sampling and
// stop check. byte_done / frame_error are single-cycle pulses.
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       frame_error
);
  import uart_mmio_pkg::*;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic        sync1, rxs, rxs_prev;
  rx_state_e   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      sync1    <= uart_rx;
      rxs      <= sync1;
      rxs_prev <= rxs;
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 16'd1;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    byte_done   = 1'b0;
    frame_error = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        // rxs_prev only reads high once the line has been idle, which re-arms
        // edge detection after a frame that ended with the line low.
        if (rxs_prev && !rxs) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shift_n   = {rxs, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          if (rxs) byte_done   = 1'b1;
          else     frame_error = 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_byte = shift;

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART on the MEM-stage bus: TXD/RXD/CON registers, transmit
// sequencer and a level interrupt request.
module uart_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h40000018,
  parameter int          CLKS_PER_BIT = 10417
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        IRQ
);
  import uart_mmio_pkg::*;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  logic sel_txd, sel_rxd, sel_con;
  logic txd_wr, con_wr, rxd_rd, con_rd;

  logic rx_int_en, tx_int_en, rx_valid, tx_busy, tx_done, frame_err, overrun;
  logic [7:0] rx_data;
  logic [CON_W-1:0] con_val;

  tx_state_e   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_line_n, tx_finish, tx_bit_end;

  logic [7:0] rx_byte;
  logic       rx_byte_done, rx_frame_error;

  logic unused_wdata;
  assign unused_wdata = ^write_data[31:8];

  assign sel_txd = (address == BASE_ADDR + TXD_OFS);
  assign sel_rxd = (address == BASE_ADDR + RXD_OFS);
  assign sel_con = (address == BASE_ADDR + CON_OFS);
  assign hit     = sel_txd | sel_rxd | sel_con;

  assign txd_wr = MemWrite & sel_txd;
  assign con_wr = MemWrite & sel_con;
  assign rxd_rd = MemRead  & sel_rxd;
  assign con_rd = MemRead  & sel_con;

  uart_rx_fsm #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .uart_rx     (uart_rx),
    .rx_byte     (rx_byte),
    .byte_done   (rx_byte_done),
    .frame_error (rx_frame_error)
  );

  assign tx_busy    = (tx_state != TX_IDLE);
  assign tx_bit_end = (tx_cnt == BIT_LAST);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_finish  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (txd_wr) begin
          tx_shift_n = write_data[7:0];
          tx_cnt_n   = '0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end else tx_cnt_n = tx_cnt + 16'd1;
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
        end else tx_cnt_n = tx_cnt + 16'd1;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
          tx_finish  = 1'b1;
        end else tx_cnt_n = tx_cnt + 16'd1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // The line level is registered from the next state so uart_tx stays
    // glitch-free and lines up with the state it belongs to.
    case (tx_state_n)
      TX_START: tx_line_n = 1'b0;
      TX_DATA:  tx_line_n = tx_shift_n[0];
      default:  tx_line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      uart_tx   <= 1'b1;
      rx_int_en <= 1'b0;
      tx_int_en <= 1'b0;
      tx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= tx_line_n;

      if (con_wr) {tx_int_en, rx_int_en} <= write_data[1:0];

      // A new event on the same edge as the clearing read wins, so it is never lost.
      if (tx_finish)           tx_done <= 1'b1;
      else if (con_rd)         tx_done <= 1'b0;
      if (rx_frame_error)      frame_err <= 1'b1;
      else if (con_rd)         frame_err <= 1'b0;
      if (rx_byte_done && rx_valid && !rxd_rd) overrun <= 1'b1;
      else if (con_rd)         overrun <= 1'b0;

      if (rx_byte_done) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rxd_rd) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    con_val                = '0;
    con_val[CON_RX_INT_EN] = rx_int_en;
    con_val[CON_TX_INT_EN] = tx_int_en;
    con_val[CON_RX_VALID]  = rx_valid;
    con_val[CON_TX_BUSY]   = tx_busy;
    con_val[CON_TX_DONE]   = tx_done;
    con_val[CON_FRAME_ERR] = frame_err;
    con_val[CON_OVERRUN]   = overrun;
  end

  always_comb begin
    read_data = '0;
    if (rxd_rd)      read_data = {24'h0, rx_data};
    else if (con_rd) read_data = {25'h0, con_val};
  end

  assign IRQ = (rx_int_en & rx_valid) | (tx_int_en & tx_done);

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: bus reads and transmitted frames are checked
// by monitors against expectations queued from a register-level model.
module tb_uart_mmio;

  localparam int          CPB  = 16;
  localparam logic [31:0] BASE = 32'h40000018;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] RXD  = BASE + 32'd4;
  localparam logic [31:0] CON  = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset, MemRead, MemWrite, hit, uart_rx, uart_tx, IRQ;
  logic [31:0] address, write_data, read_data;

  always #5 clk = ~clk;

  uart_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .hit        (hit),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx),
    .IRQ        (IRQ)
  );

  int n_vec = 0;
  int n_bad = 0;

  string       rd_name_q[$];
  logic [31:0] rd_data_q[$];
  logic        rd_hit_q[$];
  logic [7:0]  tx_q[$];
  logic        rd_tag = 1'b0;

  logic       m_rx_en, m_tx_en, m_rx_valid, m_tx_done, m_frame_err, m_overrun;
  logic [7:0] m_rx_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_con();
    return {25'h0, m_overrun, m_frame_err, m_tx_done, 1'b0, m_rx_valid, m_tx_en, m_rx_en};
  endfunction

  function automatic logic irq_exp();
    return (m_rx_en & m_rx_valid) | (m_tx_en & m_tx_done);
  endfunction

  task automatic model_reset();
    m_rx_en = 0; m_tx_en = 0; m_rx_valid = 0; m_tx_done = 0;
    m_frame_err = 0; m_overrun = 0; m_rx_data = 8'h00;
  endtask

  task automatic model_rx(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      if (m_rx_valid) m_overrun = 1'b1;
      m_rx_data  = b;
      m_rx_valid = 1'b1;
    end else begin
      m_frame_err = 1'b1;
    end
  endtask

  // Bus monitor: every tagged read is compared against the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (MemRead && rd_tag) begin
        if (rd_name_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rd_unexpected: read of %h with no expectation queued", address);
        end else begin
          string nm;
          logic [31:0] ed;
          logic eh;
          nm = rd_name_q.pop_front();
          ed = rd_data_q.pop_front();
          eh = rd_hit_q.pop_front();
          check(nm, read_data, ed);
          check({nm, "_hit"}, {31'h0, hit}, {31'h0, eh});
        end
      end
    end
  end

  // Line monitor: each start bit pops an expected byte; every cycle of the
  // 10-bit frame is compared so bit widths are checked as well as values.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && uart_tx === 1'b0) begin
        if (tx_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL tx_unexpected: start bit seen with no byte queued (t=%0t)", $time);
          for (int i = 0; i < 20 * CPB; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b1) break;
          end
        end else begin
          logic [7:0] exp_b, got;
          logic [9:0] frame;
          int bad;
          logic aborted;
          exp_b = tx_q.pop_front();
          frame = {1'b1, exp_b, 1'b0};
          bad = 0; got = '0; aborted = 1'b0;
          for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (reset) begin aborted = 1'b1; break; end
              if (uart_tx !== frame[b]) bad++;
              if (c == CPB / 2 && b >= 1 && b <= 8) got[b-1] = uart_tx;
            end
            if (aborted) break;
          end
          if (!aborted) begin
            check("tx_byte", {24'h0, got}, {24'h0, exp_b});
            check("tx_bit_timing", bad, 0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    MemWrite = 1'b1; address = addr; write_data = data;
    idle(1);
    MemWrite = 1'b0; address = '0; write_data = '0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] addr,
                          input logic [31:0] exp, input logic exp_hit);
    rd_name_q.push_back(name);
    rd_data_q.push_back(exp);
    rd_hit_q.push_back(exp_hit);
    rd_tag = 1'b1; MemRead = 1'b1; address = addr;
    idle(1);
    rd_tag = 1'b0; MemRead = 1'b0; address = '0;
  endtask

  task automatic probe_con(output logic [31:0] v);
    MemRead = 1'b1; address = CON;
    @(negedge clk);
    v = read_data;
    idle(1);
    MemRead = 1'b0; address = '0;
  endtask

  task automatic read_con(input string name);
    bus_read(name, CON, m_con(), 1'b1);
    m_tx_done = 0; m_frame_err = 0; m_overrun = 0;
  endtask

  task automatic read_rxd(input string name);
    bus_read(name, RXD, {24'h0, m_rx_data}, 1'b1);
    m_rx_valid = 0;
  endtask

  task automatic write_con(input logic [1:0] v);
    logic [31:0] d;
    d = $urandom;
    d[1:0] = v;
    bus_write(CON, d);
    m_rx_en = v[0];
    m_tx_en = v[1];
  endtask

  task automatic check_irq(input string name);
    @(negedge clk);
    check(name, {31'h0, IRQ}, {31'h0, irq_exp()});
    idle(1);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    logic [31:0] d;
    d = $urandom;
    d[7:0] = b;
    tx_q.push_back(b);
    bus_write(TXD, d);
    idle(10 * CPB + 4);
    m_tx_done = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop_bit;
    idle(CPB);
    uart_rx = 1'b1;
    idle(4);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
    send_frame(b, stop_ok);
    model_rx(b, stop_ok);
  endtask

  task automatic wait_irq(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (IRQ === 1'b1) begin lat = i; break; end
    end
  endtask

  initial begin
    logic [31:0] v, last;
    int busy_cycles, lat, edge_lat;

    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    address = '0; write_data = '0; uart_rx = 1'b1;
    model_reset();
    idle(3);
    reset = 1'b0;

    // Reset state and address decode
    @(negedge clk);
    check("rst_uart_tx", {31'h0, uart_tx}, 32'd1);
    check("rst_irq", {31'h0, IRQ}, 32'd0);
    idle(1);
    read_con("rst_con");
    read_rxd("rst_rxd");
    bus_read("txd_rd", TXD, 32'h0, 1'b1);
    bus_read("other_rd_hi", BASE + 32'd12, 32'h0, 1'b0);
    bus_read("other_rd_lo", BASE - 32'd4, 32'h0, 1'b0);
    bus_read("other_rd_off1", BASE + 32'd5, 32'h0, 1'b0);

    // TXD = A5: busy for exactly 10 bit times, then sticky tx_done
    tx_q.push_back(8'hA5);
    bus_write(TXD, 32'h123456A5);
    busy_cycles = 0;
    last = '0;
    for (int i = 0; i < 300; i++) begin
      probe_con(v);
      if (v[3]) busy_cycles++;
      else begin last = v; break; end
    end
    check("tx_busy_cycles", busy_cycles, 10 * CPB);
    check("tx_done_first_read", {31'h0, last[4]}, 32'd1);
    m_tx_done = 1'b0;
    read_con("tx_done_cleared");

    // TX interrupt
    write_con(2'b10);
    tx_byte(8'($urandom));
    check_irq("tx_irq_set");
    read_con("tx_irq_con");
    check_irq("tx_irq_clr");
    write_con(2'b00);

    for (int k = 0; k < 3; k++) begin
      tx_byte(8'($urandom));
      read_con("tx_rand_con");
    end

    // RX 3C with rx interrupt
    write_con(2'b01);
    fork
      send_frame(8'h3C, 1'b1);
      wait_irq(lat);
    join
    model_rx(8'h3C, 1'b1);
    check("rx_latency_in_bound", {31'h0, (lat > 0 && lat <= 2 + 8 + 152)}, 32'd1);
    check_irq("rx_irq_set");
    read_rxd("rxd_3c");
    check_irq("rx_irq_clr");
    read_con("rx_valid_clr");

    // Short glitch: no flags, receiver still able to take the next frame
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(30);
    read_con("glitch_con");
    read_rxd("glitch_rxd");
    for (int k = 0; k < 3; k++) begin
      rx_frame(8'($urandom), 1'b1);
      check_irq("rx_rand_irq");
      read_rxd("rx_rand_rxd");
    end

    // Bad stop bit
    rx_frame(8'h55, 1'b0);
    check_irq("ferr_irq");
    read_con("ferr_con");
    read_rxd("ferr_rxd");

    // Overrun, measuring completion latency on the first frame
    fork
      send_frame(8'h11, 1'b1);
      wait_irq(edge_lat);
    join
    model_rx(8'h11, 1'b1);
    check("ovr_latency_seen", {31'h0, (edge_lat > 2)}, 32'd1);
    rx_frame(8'h22, 1'b1);
    read_con("ovr_con");
    read_rxd("ovr_rxd");

    // RXD read landing exactly on the completion edge of the next byte
    rx_frame(8'h33, 1'b1);
    fork
      send_frame(8'h44, 1'b1);
      begin
        repeat (edge_lat - 2) @(posedge clk);
        #1;
        bus_read("edge_rxd_old", RXD, 32'h33, 1'b1);
      end
    join
    m_rx_data = 8'h44;
    m_rx_valid = 1'b1;
    read_con("edge_con");
    read_rxd("edge_rxd_new");

    // TXD write while busy is ignored
    write_con(2'b00);
    tx_q.push_back(8'h00);
    bus_write(TXD, 32'h00000000);
    idle(40);
    bus_write(TXD, 32'h000000FF);
    idle(10 * CPB);
    m_tx_done = 1'b1;
    read_con("busy_ign_con");
    read_con("busy_ign_con2");
    idle(12 * CPB);

    // Reset in the middle of a frame
    write_con(2'b11);
    tx_q.push_back(8'h5A);
    bus_write(TXD, 32'h0000005A);
    idle(50);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    model_reset();
    fork
      bus_read("rst_mid_con", CON, 32'h0, 1'b1);
      begin
        @(negedge clk);
        check("rst_mid_uart_tx", {31'h0, uart_tx}, 32'd1);
        check("rst_mid_irq", {31'h0, IRQ}, 32'd0);
      end
    join
    idle(12 * CPB);

    check("tx_q_drained", tx_q.size(), 0);
    check("rd_q_drained", rd_name_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART peripheral on the CPU's MEM-stage bus: consumes the MemRead/MemWrite/address/write_data it drives and returns read_data plus an interrupt request.
- Transmits and receives 8N1 frames and provides TXD, RXD and CON registers.
- IRQ feeds the CPU's exception/interrupt logic.

Parameters:
- BASE_ADDR, 32'h40000018, byte address of TXD; RXD = BASE_ADDR+4, CON = BASE_ADDR+8.
- CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600); legal range 4..65535.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- MemRead  in  1  bus read strobe (MEM stage).
- MemWrite  in  1  bus write strobe (MEM stage).
- address  in  32  byte address; only exact matches of TXD/RXD/CON decode.
- write_data  in  32  store data; only bits [7:0] or CON bits [1:0] used.
- read_data  out  32  combinational read data; 0 when not selected.
- hit  out  1  combinational: address matches any UART register.
- uart_rx  in  1  asynchronous serial input, idle high.
- uart_tx  out  1  serial output, idle high.
- IRQ  out  1  interrupt request, level.

Behaviour:
- Reset (synchronous, active-high): uart_tx=1; TX FSM IDLE; RX FSM IDLE; rx_data=0; CON=0; IRQ=0; synchronizer flops=1. Reset mid-frame aborts the frame immediately; uart_tx returns high on the next edge.
- read_data is combinational:
  - RXD read (MemRead & address==RXD) -> {24'h0, rx_data}.
  - CON read -> {25'h0, overrun, frame_err, tx_done, tx_busy, rx_valid, tx_int_en, rx_int_en}.
  - TXD read -> 0.
  - Any other case -> 0.
- CON bits:
  - [0] rx_int_en, RW.
  - [1] tx_int_en, RW.
  - [2] rx_valid, RO.
  - [3] tx_busy, RO.
  - [4] tx_done, sticky.
  - [5] frame_err, sticky.
  - [6] overrun, sticky.
  - Sticky bits clear on the clock edge ending a CON read.
  - A CON write updates [1:0] only.
- TX FSM (IDLE, START, DATA, STOP):
  - A write to TXD in IDLE latches write_data[7:0] and enters START on that edge. tx_busy=1 from the next cycle.
  - START drives 0; DATA drives bits LSB first; STOP drives 1. Each bit lasts exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
  - On STOP completion: return to IDLE, tx_busy=0, set tx_done.
  - A TXD write while busy is ignored: no latch, no flag.
- RX path:
  - uart_rx passes through a 2-flop synchronizer; rxs is the synchronized value.
  - IDLE: a falling edge of rxs enters START and counts CLKS_PER_BIT/2 cycles (integer division).
    - At that point, rxs==0 -> DATA.
    - Otherwise false start -> IDLE with no flags.
  - DATA: sample at each CLKS_PER_BIT interval, LSB first, 8 samples. STOP: sample once more after CLKS_PER_BIT.
  - Stop sample ==1: rx_data <= shifted byte; rx_valid <= 1. If rx_valid was already 1, set overrun; new data overwrites.
  - Stop sample ==0: set frame_err, discard byte, rx_valid unchanged.
  - Return to IDLE and wait for rxs high before re-arming edge detection.
- RXD read clears rx_valid on the edge ending the read. If a byte completes on that same edge, the new byte is stored, rx_valid stays 1, and overrun is not set.
- IRQ = (rx_int_en & rx_valid) | (tx_int_en & tx_done). It is combinational from registered state and drops when the source flag clears.
- A write and a read in the same cycle cannot occur on the bus; if they do, the write takes effect and the read is still returned.
- Counters are 16-bit and wrap never occurs within the legal range.

Decomposition:
- Shared package holds:
  - Register offsets (TXD_OFS=0, RXD_OFS=4, CON_OFS=8).
  - CON bit index constants.
  - TX/RX state encodings (2-bit).
- One natural sub-module, uart_rx_fsm: synchronizer, start validation, sampling, stop check. Outputs byte, byte_done, frame_error pulses.
- TX FSM and register file stay in uart_mmio.

Test Plan:
- CLKS_PER_BIT=16, write TXD=8'hA5 -> uart_tx: 0 for 16 cycles, then 1,0,1,0,0,1,0,1 (16 each), then 1. tx_busy=1 for 160 cycles, then tx_done=1; CON read returns bit4=1 and the next CON read returns bit4=0.
- Drive a valid 8'h3C frame on uart_rx with rx_int_en=1 -> rx_valid=1 and IRQ=1 within 2+8+152 cycles of the start edge. RXD read returns 32'h3C, and rx_valid and IRQ are 0 the cycle after.
- Low glitch of 4 cycles on uart_rx -> no state change, no flags, uart_rx_fsm back in IDLE.
- Frame 8'h55 with stop bit 0 -> frame_err=1, rx_valid stays 0, rx_data unchanged.
- Two frames 8'h11 then 8'h22 without reading -> rx_data=8'h22, overrun=1. Separately, an RXD read on the exact completion edge -> rx_valid stays 1 and overrun=0.
- TXD write of 8'hFF while busy with 8'h00 -> transmitted frame is all-zero data, one tx_done; reset asserted mid-frame -> uart_tx=1 and CON=0 the next cycle.
